// File: rtl/dac_serializer.sv
// Multi-channel DAC serializer. Accepts one multi-channel sample per frame through a
// one-entry holding buffer and shifts each channel out MSB first. A one-cycle active-low
// latch strobe follows the LSB of every word.
// Optional feature: define DAC_UNDERRUN_CNT_EN to add the saturating 8-bit underrun_cnt port.
module dac_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                        clk_12,
  input  logic                        reset_n,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [CHANNELS-1:0]         dout,
  output logic [CHANNELS-1:0]         latch_n,
  output logic                        underrun
`ifdef DAC_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                  underrun_cnt
`endif
);

  localparam int unsigned DataW = CHANNELS * WIDTH;
  localparam int unsigned CntW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt  = CntW'(FRAME_LEN - 1);
  localparam logic [CntW-1:0] WidthCnt = CntW'(WIDTH);

  // Elaboration-time parameter checks
  if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
    $error("dac_serializer: WIDTH must be in 8..32");
  end
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("dac_serializer: CHANNELS must be in 1..8");
  end
  if (FRAME_LEN < WIDTH + 2) begin : g_bad_frame
    $error("dac_serializer: FRAME_LEN must be >= WIDTH+2");
  end

  typedef enum logic {StIdle, StRun} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       fcnt_q, fcnt_d;
  logic [DataW-1:0]      buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [DataW-1:0]      shreg_q, shreg_d;
  // Copy of the word currently being played, replayed on underrun
  logic [DataW-1:0]      cur_q, cur_d;
  logic [CHANNELS-1:0]   dout_q, dout_d;
  logic [CHANNELS-1:0]   latch_n_q, latch_n_d;
  logic                  underrun_q, underrun_d;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [7:0]            ucnt_q, ucnt_d;
`endif

  logic wrap;
  logic load;
  logic accept;

  assign wrap     = (state_q == StRun) && (fcnt_q == LastCnt);
  // Buffer drains into the shift registers when leaving IDLE or at a frame wrap
  assign load     = buf_full_q && ((state_q == StIdle) || wrap);
  assign in_ready = ~buf_full_q | load;
  assign accept   = in_valid & in_ready;

  // Next-state logic: FSM, frame counter, buffer, shift registers and registered outputs
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    cur_d      = cur_q;
    underrun_d = underrun_q;
    dout_d     = '0;
    latch_n_d  = '1;
`ifdef DAC_UNDERRUN_CNT_EN
    ucnt_d     = ucnt_q;
`endif

    if (load) begin
      buf_full_d = 1'b0;
      shreg_d    = buf_q;
      cur_d      = buf_q;
    end
    // Accept after load so a same-edge load and accept leaves the buffer full
    if (accept) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        fcnt_d = '0;
        if (buf_full_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (fcnt_q < WidthCnt) begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            dout_d[c] = shreg_q[c*WIDTH + WIDTH - 1];
            shreg_d[c*WIDTH +: WIDTH] = {shreg_q[c*WIDTH +: WIDTH-1], 1'b0};
          end
        end
        if (fcnt_q == WidthCnt) begin
          latch_n_d = '0;
        end
        if (wrap) begin
          fcnt_d = '0;
          if (!buf_full_q) begin
            shreg_d    = cur_q;
            underrun_d = 1'b1;
`ifdef DAC_UNDERRUN_CNT_EN
            if (ucnt_q != 8'hFF) begin
              ucnt_d = ucnt_q + 8'd1;
            end
`endif
          end
        end else begin
          fcnt_d = fcnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      fcnt_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      cur_q      <= '0;
      dout_q     <= '0;
      latch_n_q  <= '1;
      underrun_q <= 1'b0;
`ifdef DAC_UNDERRUN_CNT_EN
      ucnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      cur_q      <= cur_d;
      dout_q     <= dout_d;
      latch_n_q  <= latch_n_d;
      underrun_q <= underrun_d;
`ifdef DAC_UNDERRUN_CNT_EN
      ucnt_q     <= ucnt_d;
`endif
    end
  end

  assign dout     = dout_q;
  assign latch_n  = latch_n_q;
  assign underrun = underrun_q;
`ifdef DAC_UNDERRUN_CNT_EN
  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 Parameter WIDTH, default 16: sample bits per channel, legal range 8..32.
REQ-002 Parameter CHANNELS, default 2: number of independent serial outputs, legal range 1..8.
REQ-003 Parameter FRAME_LEN, default 256: clk_12 cycles per sample frame; must be >= WIDTH+2.
REQ-004 Port clk_12, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_data, input, CHANNELS*WIDTH bits: two's-complement samples; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 Port dout, output, CHANNELS bits: serial data per channel, MSB first.
REQ-010 Port latch_n, output, CHANNELS bits: active-low, one-cycle word-latch strobe per channel.
REQ-011 Port underrun, output, 1 bit: sticky flag, set on the first frame that starts without new data.

Function
REQ-012 The block accepts a sample when in_valid and in_ready are both high on a rising edge.
REQ-013 The block holds accepted samples in a one-entry holding buffer.
REQ-014 in_ready is high when the holding buffer is empty, or when the buffer is being loaded into the shift registers in the same cycle.
REQ-015 An accept and a shift-register load on the same edge are both performed: the old buffer contents move to the shift registers and the new sample enters the buffer.
REQ-016 The block has two states: IDLE (after reset) and RUN.
- IDLE: dout is 0, latch_n is all 1s, and the frame counter fcnt is held at 0.
- IDLE -> RUN: on the edge after the buffer becomes full, the buffer is loaded into the shift registers and fcnt is 0.
REQ-017 In RUN, fcnt counts 0..FRAME_LEN-1 and wraps to 0.
REQ-018 At the wrap to 0, the shift registers load from the buffer if it is full; otherwise they reload the previous sample, underrun is set, and the block stays in RUN.
REQ-019 In a frame where fcnt = k < WIDTH, dout[c] is a registered output equal to bit WIDTH-1-k of channel c; at fcnt >= WIDTH, dout is 0.
REQ-020 latch_n is all 0s only while fcnt == WIDTH in RUN; it is 1 at all other times.
REQ-021 A receiver that shifts dout on rising clk_12 edges and captures on the falling edge of latch_n obtains the exact WIDTH-bit word.
REQ-022 Latency from the accept edge to the MSB appearing on dout is 2 clk_12 cycles when starting from IDLE.
REQ-023 Samples are passed bit-exact, with no sign extension or truncation.
REQ-024 Illegal parameter values cause an elaboration-time $error.

Reset
REQ-025 Asserting reset_n low at any time, including mid-frame, immediately sets the following and the block re-enters IDLE on release:
- state = IDLE, fcnt = 0, buffer empty, shift registers 0;
- dout = 0, latch_n = all 1s, underrun = 0, in_ready = 1, underrun_cnt = 0.
REQ-026 underrun clears only on reset.

Configuration
REQ-027 When macro DAC_UNDERRUN_CNT_EN is defined, the block adds an output port underrun_cnt (8 bits).
- It increments once per underrun frame and saturates at 255.
REQ-028 When DAC_UNDERRUN_CNT_EN is undefined, the underrun_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-029 Defaults; reset, then accept L=0x0009, R=0x0006 -> dout[0] shows 0x0009 MSB-first and dout[1] shows 0x0006 on cycles 2..17 after the accept; latch_n=00 on cycle 18; receiver captures 0x0009/0x0006.
REQ-030 Hold in_valid high continuously with a new value each accept -> in_ready pulses once per 256 cycles; every sample appears exactly once and in order; underrun stays 0.
REQ-031 Feed one sample 0x8001 then stop -> the next frame repeats 0x8001; underrun = 1 from that frame onward; underrun_cnt = 1, 2, ... and saturates at 255 (macro defined).
REQ-032 Assert reset_n at fcnt = 7 mid-shift -> dout = 0 and latch_n = 11 immediately; no latch pulse occurs; after release, the next accept restarts with 2-cycle latency.
REQ-033 WIDTH=24, CHANNELS=4, FRAME_LEN=26; send 0x7FFFFF, 0x800000, 0x000001, 0xFFFFFF -> all four words are recovered per frame; latch_n = 0000 at fcnt = 24 only.
REQ-034 Assert in_valid on the same edge as the frame wrap with the buffer full -> the old sample loads, the new sample is accepted, and no sample is lost or duplicated.
